// File: rtl/sdram_read_arbiter_if.sv
// Bundle of requester, SDRAM read-port and status signals around the read arbiter.
// The arbiter connects through the master modport; requesters and memory use slave.
interface sdram_read_arbiter_if;
  logic        req_a;
  logic [21:0] addr_a;
  logic [31:0] data_a;
  logic        ready_a;
  logic        req_b;
  logic [21:0] addr_b;
  logic [31:0] data_b;
  logic        ready_b;
  logic [21:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [1:0]  grant;
  logic        timeout;

  modport master (
    input  req_a, addr_a, req_b, addr_b, mem_data, mem_ready,
    output data_a, ready_a, data_b, ready_b, mem_addr, mem_req, grant, timeout
  );

  modport slave (
    output req_a, addr_a, req_b, addr_b, mem_data, mem_ready,
    input  data_a, ready_a, data_b, ready_b, mem_addr, mem_req, grant, timeout
  );
endinterface

// File: rtl/sdram_read_arbiter.sv
// Two-port SDRAM read arbiter: A has priority, a burst counter forces B after
// A_BURST_MAX contended A grants; one read in flight, with a sticky timeout.
module sdram_read_arbiter #(
  parameter int unsigned A_BURST_MAX = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  sdram_read_arbiter_if.master bus
);

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam int unsigned BW = $clog2(A_BURST_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            mem_req_q, mem_req_d;
  logic [1:0]      grant_q, grant_d;
  logic [DW-1:0]   data_a_q, data_a_d;
  logic [DW-1:0]   data_b_q, data_b_d;
  logic            ready_a_q, ready_a_d;
  logic            ready_b_q, ready_b_d;
  logic            timeout_q, timeout_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      burst_q    <= '0;
      tmo_q      <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      grant_q    <= 2'b00;
      data_a_q   <= '0;
      data_b_q   <= '0;
      ready_a_q  <= 1'b0;
      ready_b_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      tmo_q      <= tmo_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      grant_q    <= grant_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      ready_a_q  <= ready_a_d;
      ready_b_q  <= ready_b_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    tmo_d      = tmo_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    grant_d    = grant_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    ready_a_d  = 1'b0;
    ready_b_d  = 1'b0;
    timeout_d  = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_a && (!bus.req_b || burst_q != BW'(A_BURST_MAX))) begin
          grant_d    = 2'b01;
          mem_addr_d = bus.addr_a;
          state_d    = S_ISSUE;
          // Below the limit here, so the increment cannot pass A_BURST_MAX
          burst_d    = bus.req_b ? burst_q + BW'(1) : '0;
        end else if (bus.req_b) begin
          grant_d    = 2'b10;
          mem_addr_d = bus.addr_b;
          state_d    = S_ISSUE;
          burst_d    = '0;
        end
      end

      S_ISSUE: begin
        mem_req_d = 1'b1;
        tmo_d     = '0;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        if (bus.mem_ready) begin
          if (grant_q[0]) begin
            data_a_d  = bus.mem_data;
            ready_a_d = 1'b1;
          end else begin
            data_b_d  = bus.mem_data;
            ready_b_d = 1'b1;
          end
          mem_req_d = 1'b0;
          grant_d   = 2'b00;
          state_d   = S_RELEASE;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          mem_req_d = 1'b0;
          timeout_d = 1'b1;
          grant_d   = 2'b00;
          state_d   = S_RELEASE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_RELEASE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.grant    = grant_q;
  assign bus.data_a   = data_a_q;
  assign bus.data_b   = data_b_q;
  assign bus.ready_a  = ready_a_q;
  assign bus.ready_b  = ready_b_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed self-checking bench for sdram_read_arbiter; inputs change 1 time unit
// after the rising edge and outputs are sampled at the same point.
module tb_sdram_read_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  sdram_read_arbiter_if bus ();

  sdram_read_arbiter #(.A_BURST_MAX(4), .TIMEOUT_CYC(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++; if (bus.grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b exp=00", bus.grant); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
    total++; if ({bus.ready_a, bus.ready_b, bus.timeout} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {bus.ready_a, bus.ready_b, bus.timeout}); end
    total++; if ({bus.data_a, bus.data_b, bus.mem_addr} !== 86'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", {bus.data_a, bus.data_b, bus.mem_addr}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_a_only();
    bus.req_a = 1'b1; bus.addr_a = 22'h000004;
    tick();
    total++; if (bus.grant !== 2'b01) begin bad++; $display("FAIL a1_grant got=%b exp=01", bus.grant); end
    total++; if (bus.mem_addr !== 22'h000004) begin bad++; $display("FAIL a1_addr got=%h exp=000004", bus.mem_addr); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL a1_req_early got=%b exp=0", bus.mem_req); end
    tick();
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL a1_mem_req got=%b exp=1", bus.mem_req); end
    repeat (2) tick();
    bus.mem_ready = 1'b1; bus.mem_data = 32'hDEADBEEF;
    tick();
    total++; if (bus.ready_a !== 1'b1 || bus.ready_b !== 1'b0) begin bad++; $display("FAIL a1_ready got=%b%b exp=10", bus.ready_a, bus.ready_b); end
    total++; if (bus.data_a !== 32'hDEADBEEF) begin bad++; $display("FAIL a1_data got=%h exp=deadbeef", bus.data_a); end
    total++; if (bus.grant !== 2'b00 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL a1_release got=%b/%b exp=00/0", bus.grant, bus.mem_req); end
    bus.mem_ready = 1'b0; bus.req_a = 1'b0;
    tick();
    total++; if (bus.ready_a !== 1'b0) begin bad++; $display("FAIL a1_pulse_width got=%b exp=0", bus.ready_a); end
    total++; if (bus.data_a !== 32'hDEADBEEF || bus.data_b !== 32'h0) begin bad++; $display("FAIL a1_hold got=%h/%h exp=deadbeef/0", bus.data_a, bus.data_b); end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g;
    logic [21:0] exp_addr;
    bus.req_a = 1'b1; bus.addr_a = 22'h000100;
    bus.req_b = 1'b1; bus.addr_b = 22'h000200;
    for (int i = 0; i < 10; i++) begin
      exp_g    = (i % 5 == 4) ? 2'b10 : 2'b01;
      exp_addr = (i % 5 == 4) ? 22'h000200 : 22'h000100;
      tick();
      total++; if (bus.grant !== exp_g) begin bad++; $display("FAIL cont_grant%0d got=%b exp=%b", i, bus.grant, exp_g); end
      total++; if (bus.mem_addr !== exp_addr) begin bad++; $display("FAIL cont_addr%0d got=%h exp=%h", i, bus.mem_addr, exp_addr); end
      tick();
      bus.mem_ready = 1'b1; bus.mem_data = 32'h0000_1000 + 32'(i);
      tick();
      total++; if ({bus.ready_b, bus.ready_a} !== exp_g) begin bad++; $display("FAIL cont_ready%0d got=%b%b exp=%b", i, bus.ready_b, bus.ready_a, exp_g); end
      if (exp_g == 2'b10) begin
        total++; if (bus.data_b !== 32'h0000_1000 + 32'(i)) begin bad++; $display("FAIL cont_data_b%0d got=%h exp=%h", i, bus.data_b, 32'h0000_1000 + 32'(i)); end
      end else begin
        total++; if (bus.data_a !== 32'h0000_1000 + 32'(i)) begin bad++; $display("FAIL cont_data_a%0d got=%h exp=%h", i, bus.data_a, 32'h0000_1000 + 32'(i)); end
      end
      bus.mem_ready = 1'b0;
      if (i == 9) begin bus.req_a = 1'b0; bus.req_b = 1'b0; end
      tick();
    end
    tick();
    total++; if (bus.grant !== 2'b00) begin bad++; $display("FAIL cont_idle got=%b exp=00", bus.grant); end
  endtask

  task automatic test_timeout();
    int   n;
    logic saw_ready;
    bus.req_b = 1'b1; bus.addr_b = 22'h3FFFFF;
    tick();
    total++; if (bus.grant !== 2'b10) begin bad++; $display("FAIL tmo_grant got=%b exp=10", bus.grant); end
    tick();
    n = 0; saw_ready = 1'b0;
    while (bus.mem_req === 1'b1 && n < 2000) begin
      n++;
      tick();
      if (bus.ready_b === 1'b1 || bus.ready_a === 1'b1) saw_ready = 1'b1;
    end
    total++; if (n != 1024) begin bad++; $display("FAIL tmo_req_cycles got=%0d exp=1024", n); end
    total++; if (saw_ready !== 1'b0) begin bad++; $display("FAIL tmo_spurious_ready got=%b exp=0", saw_ready); end
    total++; if (bus.timeout !== 1'b1 || bus.grant !== 2'b00) begin bad++; $display("FAIL tmo_flag got=%b/%b exp=1/00", bus.timeout, bus.grant); end
    bus.req_b = 1'b0;
    tick();
    bus.req_a = 1'b1; bus.addr_a = 22'h000008;
    tick();
    total++; if (bus.grant !== 2'b01) begin bad++; $display("FAIL tmo_a_grant got=%b exp=01", bus.grant); end
    tick();
    bus.mem_ready = 1'b1; bus.mem_data = 32'hCAFEF00D;
    tick();
    total++; if (bus.ready_a !== 1'b1 || bus.data_a !== 32'hCAFEF00D) begin bad++; $display("FAIL tmo_a_read got=%b/%h exp=1/cafef00d", bus.ready_a, bus.data_a); end
    total++; if (bus.data_b !== 32'h0000_1009) begin bad++; $display("FAIL tmo_data_b got=%h exp=00001009", bus.data_b); end
    bus.mem_ready = 1'b0; bus.req_a = 1'b0;
    tick();
    total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b exp=1", bus.timeout); end
    tick();
  endtask

  task automatic test_level_ready();
    int pulses;
    bus.req_a = 1'b1; bus.addr_a = 22'h000010;
    tick();
    tick();
    bus.mem_ready = 1'b1; bus.mem_data = 32'hA5A5A5A5;
    tick();
    pulses = int'(bus.ready_a);
    total++; if (bus.data_a !== 32'hA5A5A5A5) begin bad++; $display("FAIL lvl_data got=%h exp=a5a5a5a5", bus.data_a); end
    bus.addr_a = 22'h000020; bus.mem_data = 32'h11111111;
    tick();
    pulses += int'(bus.ready_a);
    tick();
    pulses += int'(bus.ready_a);
    total++; if (bus.grant !== 2'b01 || bus.mem_addr !== 22'h000020) begin bad++; $display("FAIL lvl_regrant got=%b/%h exp=01/000020", bus.grant, bus.mem_addr); end
    bus.mem_ready = 1'b0;
    tick();
    pulses += int'(bus.ready_a);
    total++; if (pulses != 1) begin bad++; $display("FAIL lvl_pulses got=%0d exp=1", pulses); end
    tick();
    total++; if (bus.ready_a !== 1'b0 || bus.mem_req !== 1'b1 || bus.data_a !== 32'hA5A5A5A5) begin bad++; $display("FAIL lvl_stale got=%b/%b/%h exp=0/1/a5a5a5a5", bus.ready_a, bus.mem_req, bus.data_a); end
    bus.mem_ready = 1'b1; bus.mem_data = 32'h22222222;
    tick();
    total++; if (bus.ready_a !== 1'b1 || bus.data_a !== 32'h22222222) begin bad++; $display("FAIL lvl_second got=%b/%h exp=1/22222222", bus.ready_a, bus.data_a); end
    bus.mem_ready = 1'b0; bus.req_a = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_in_wait();
    bus.req_a = 1'b1; bus.addr_a = 22'h000030;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.mem_req !== 1'b0 || bus.grant !== 2'b00) begin bad++; $display("FAIL arst_bus got=%b/%b exp=0/00", bus.mem_req, bus.grant); end
    total++; if (bus.timeout !== 1'b0 || bus.data_a !== 32'h0 || bus.data_b !== 32'h0 || bus.mem_addr !== 22'h0) begin bad++; $display("FAIL arst_regs got=%b/%h/%h/%h exp=0/0/0/0", bus.timeout, bus.data_a, bus.data_b, bus.mem_addr); end
    tick();
    total++; if (bus.ready_a !== 1'b0) begin bad++; $display("FAIL arst_no_ready got=%b exp=0", bus.ready_a); end
    rst_n = 1'b1;
    tick();
    total++; if (bus.grant !== 2'b01 || bus.mem_addr !== 22'h000030) begin bad++; $display("FAIL arst_regrant got=%b/%h exp=01/000030", bus.grant, bus.mem_addr); end
    tick();
    bus.mem_ready = 1'b1; bus.mem_data = 32'h33333333;
    tick();
    total++; if (bus.ready_a !== 1'b1 || bus.data_a !== 32'h33333333) begin bad++; $display("FAIL arst_read got=%b/%h exp=1/33333333", bus.ready_a, bus.data_a); end
    bus.mem_ready = 1'b0; bus.req_a = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_withdrawal();
    bus.req_a = 1'b1; bus.addr_a = 22'h000040;
    bus.req_b = 1'b1; bus.addr_b = 22'h000050;
    tick();
    total++; if (bus.grant !== 2'b01) begin bad++; $display("FAIL wd_grant_a got=%b exp=01", bus.grant); end
    bus.req_a = 1'b0; bus.addr_a = 22'h0003FF;
    tick();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 22'h000040) begin bad++; $display("FAIL wd_capture got=%b/%h exp=1/000040", bus.mem_req, bus.mem_addr); end
    bus.mem_ready = 1'b1; bus.mem_data = 32'h44444444;
    tick();
    total++; if (bus.ready_a !== 1'b1 || bus.data_a !== 32'h44444444 || bus.data_b !== 32'h0) begin bad++; $display("FAIL wd_a_done got=%b/%h/%h exp=1/44444444/0", bus.ready_a, bus.data_a, bus.data_b); end
    bus.mem_ready = 1'b0;
    tick();
    tick();
    total++; if (bus.grant !== 2'b10 || bus.mem_addr !== 22'h000050) begin bad++; $display("FAIL wd_grant_b got=%b/%h exp=10/000050", bus.grant, bus.mem_addr); end
    tick();
    bus.mem_ready = 1'b1; bus.mem_data = 32'h55555555;
    tick();
    total++; if (bus.ready_b !== 1'b1 || bus.data_b !== 32'h55555555 || bus.data_a !== 32'h44444444) begin bad++; $display("FAIL wd_b_done got=%b/%h/%h exp=1/55555555/44444444", bus.ready_b, bus.data_b, bus.data_a); end
    bus.mem_ready = 1'b0; bus.req_b = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_a     = 1'b0;
    bus.addr_a    = '0;
    bus.req_b     = 1'b0;
    bus.addr_b    = '0;
    bus.mem_data  = '0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_a_only();
    test_contention();
    test_timeout();
    test_level_ready();
    test_reset_in_wait();
    test_withdrawal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
